// File: rtl/pipo_shift_ctrl.sv
// Parallel-load shift register controller: loads a word, shifts it left a
// clamped number of times, pulses done and counts completed operations.
module pipo_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic [7:0]       op_count,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is accepted on the rising edge where start=1 and
  // ready=1; start while ready=0 is dropped, nothing is queued.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [7:0]       op_q, op_d;
  logic [CNT_W-1:0] clamped;

  assign clamped = (shift_count > MAX_CNT) ? MAX_CNT : shift_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sout_q  <= 1'b0;
      op_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sout_d  = sout_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = load_data;
          cnt_d   = clamped;
          state_d = (clamped != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        // abort wins over the final shift: registers hold, no DONE visit
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          data_d = {data_q[WIDTH-2:0], 1'b0};
          sout_d = data_q[WIDTH-1];
          cnt_d  = cnt_q - ONE;
          if (cnt_q == ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (op_q != 8'hFF) op_d = op_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready      = (state_q == S_IDLE);
  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign op_count   = op_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pipo_shift_ctrl.sv
// Directed bench for pipo_shift_ctrl: load/shift sequences, clamping, abort,
// start-while-busy, asynchronous reset and op_count saturation.
module tb_pipo_shift_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] shift_count;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic [7:0]       op_count;
  logic [1:0]       state_dbg;

  int n_tests;
  int n_fail;
  logic [WIDTH-1:0] exp_q[$];

  pipo_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .load_data   (load_data),
    .shift_count (shift_count),
    .abort       (abort),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .serial_out  (serial_out),
    .op_count    (op_count),
    .state_dbg   (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c);
    start       = 1'b1;
    load_data   = d;
    shift_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic check_data_from_q(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, data_out, e);
    end
  endtask

  initial begin
    int dones;
    int shifts;
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    load_data   = '0;
    shift_count = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_out, 0);
    check("rst_sout", serial_out, 0);
    check("rst_op", op_count, 0);
    reset = 1'b0;
    tick();

    // 1011 shifted twice
    start_op(4'b1011, 3'd2);
    check("t1_load", data_out, 4'b1011);
    check("t1_busy", busy, 1);
    check("t1_done0", done, 0);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1100);
    tick();
    check_data_from_q("t1_sh1");
    check("t1_sout1", serial_out, 1);
    check("t1_done1", done, 0);
    tick();
    check_data_from_q("t1_sh2");
    check("t1_sout2", serial_out, 0);
    check("t1_done2", done, 1);
    tick();
    check("t1_done3", done, 0);
    check("t1_ready", ready, 1);
    check("t1_op", op_count, 1);

    // zero count goes straight to DONE
    start_op(4'b0101, 3'd0);
    check("t2_busy", busy, 0);
    check("t2_done", done, 1);
    check("t2_data", data_out, 4'b0101);
    tick();
    check("t2_done_off", done, 0);
    check("t2_op", op_count, 2);
    check("t2_sout", serial_out, 0);

    // count 7 clamps to 4
    start_op(4'b1101, 3'd7);
    dones  = 0;
    shifts = busy ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
      if (busy) shifts++;
    end
    check("t3_shifts", shifts, 4);
    check("t3_dones", dones, 1);
    check("t3_data", data_out, 4'b0000);
    check("t3_sout", serial_out, 1);
    check("t3_op", op_count, 3);

    // abort after the first shift
    start_op(4'b1111, 3'd3);
    tick();
    check("t4_sh1", data_out, 4'b1110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_ready", ready, 1);
    check("t4_done", done, 0);
    check("t4_data", data_out, 4'b1110);
    check("t4_sout", serial_out, 1);
    tick();
    check("t4_done2", done, 0);
    check("t4_data2", data_out, 4'b1110);
    check("t4_op", op_count, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_idle_abort", ready, 1);
    check("t4_idle_data", data_out, 4'b1110);

    // start and load_data changes while busy are ignored
    start_op(4'b0011, 3'd3);
    start     = 1'b1;
    load_data = 4'b1111;
    tick();
    check("t5_sh1", data_out, 4'b0110);
    tick();
    check("t5_sh2", data_out, 4'b1100);
    tick();
    check("t5_sh3", data_out, 4'b1000);
    check("t5_done", done, 1);
    start = 1'b0;
    tick();
    check("t5_ready", ready, 1);
    check("t5_data", data_out, 4'b1000);
    check("t5_op", op_count, 4);

    // start with abort in IDLE is accepted
    abort = 1'b1;
    start_op(4'b1001, 3'd1);
    abort = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_data", data_out, 4'b1001);
    tick();
    check("t6_done", done, 1);
    check("t6_shift", data_out, 4'b0010);
    tick();
    check("t6_op", op_count, 5);

    // asynchronous reset mid-shift
    start_op(4'b1111, 3'd4);
    tick();
    #2 reset = 1'b1;
    #1;
    check("t7_ready", ready, 1);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
    check("t7_data", data_out, 0);
    check("t7_sout", serial_out, 0);
    check("t7_op", op_count, 0);
    #1 reset = 1'b0;
    start_op(4'b0110, 3'd1);
    check("t7_accept", busy, 1);
    check("t7_load", data_out, 4'b0110);
    tick();
    check("t7_done_pulse", done, 1);
    tick();
    check("t7_op1", op_count, 1);

    // saturation of op_count
    for (int i = 0; i < 256; i++) begin
      start_op(4'b0001, 3'd0);
      tick();
    end
    check("t8_sat", op_count, 255);
    start_op(4'b0001, 3'd0);
    tick();
    check("t8_hold", op_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipo_shift_ctrl.md
PIPO_SHIFT_CTRL -- requirements
Module: pipo_shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data register width in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, shift-count field width; the field SHALL hold the value WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  operation request; sampled only when ready=1.
REQ-006 SHALL have port load_data  input  WIDTH  word loaded into the data register on start acceptance.
REQ-007 SHALL have port shift_count  input  CNT_W  number of left shifts to apply after the load.
REQ-008 SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-009 SHALL have port ready  output  1  high in IDLE only.
REQ-010 SHALL have port busy  output  1  high in SHIFT only.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port data_out  output  WIDTH  current data register contents.
REQ-013 SHALL have port serial_out  output  1  last bit shifted out of the MSB.
REQ-014 SHALL have port op_count  output  8  completed-operation counter.

Function
REQ-015 SHALL implement an FSM with states IDLE, SHIFT and DONE, plus an internal CNT_W-bit remaining-shift counter.
REQ-016 In IDLE with start=1 the block SHALL, on that edge: load data register <= load_data; load counter <= min(shift_count, WIDTH); go to SHIFT if the clamped count > 0, else go to DONE.
REQ-017 In SHIFT, each edge SHALL: set data register <= {data[WIDTH-2:0], 1'b0}; set serial_out <= old data[WIDTH-1]; decrement counter; on the edge where counter==1, go to DONE.
REQ-018 For an accepted start at edge k with clamped count N, shifts SHALL occur at edges k+1..k+N, done SHALL be high for exactly the cycle following edge k+N (k+1 when N=0), and the FSM SHALL return to IDLE at the next edge.
REQ-019 In DONE, op_count SHALL increment by 1, saturating at 255; done SHALL be a Moore output (state==DONE).
REQ-020 start SHALL be ignored in SHIFT and DONE; there is no queueing, and the requester must wait for ready=1.
REQ-021 abort=1 in SHIFT SHALL return the FSM to IDLE on the next edge; data_out and serial_out SHALL hold their values, no done pulse SHALL occur, and op_count SHALL not change.
REQ-022 abort SHALL have priority over the final shift, so abort in the cycle with counter==1 skips that shift and DONE; abort in IDLE or DONE SHALL have no effect.
REQ-023 Simultaneous start and abort in IDLE SHALL accept the start.
REQ-024 shift_count values above WIDTH SHALL be clamped to WIDTH, which yields an all-zero result.
REQ-025 data_out and serial_out SHALL change only on a load or a shift.

Reset
REQ-026 reset=1 SHALL asynchronously force: state=IDLE, counter=0, data_out=0, serial_out=0, op_count=0, ready=1, busy=0, done=0.
REQ-027 Reset asserted mid-operation SHALL abandon that operation without a done pulse; the first edge after deassertion SHALL be able to accept a start.

Verification
REQ-028 Bench SHALL cover: load_data=4'b1011, shift_count=2 -> data_out 1011, 0110, 1100 on successive cycles; serial_out 1 then 0; done high one cycle, 3 cycles after the accept edge; op_count=1.
REQ-029 Bench SHALL cover: shift_count=0, load_data=4'b0101 -> busy never high; done in the cycle after acceptance; data_out=0101.
REQ-030 Bench SHALL cover: shift_count=7 with WIDTH=4 -> exactly 4 shifts; data_out=0000; done once.
REQ-031 Bench SHALL cover: abort one cycle after a start with shift_count=3, load 4'b1111 -> data_out=1110 held; no done; ready=1 on the next cycle; op_count unchanged.
REQ-032 Bench SHALL cover: start pulsed while busy -> ignored; load_data changes while busy do not affect data_out.
REQ-033 Bench SHALL cover: reset asserted asynchronously mid-SHIFT -> all outputs reach reset values before the next edge; 256 completed ops -> op_count holds 255.
